// File: rtl/decode_ctrl_stage_pkg.sv
// Shared definitions for the decode control stage: opcode encodings,
// control-bundle field ordering and mul/div FSM state encodings.
package decode_ctrl_stage_pkg;

    localparam int PKG_OPCODE_W = 12;

    // R-type ALU ops (read rs1 and rs2)
    localparam logic [PKG_OPCODE_W-1:0] OP_ADD  = 12'h001;
    localparam logic [PKG_OPCODE_W-1:0] OP_SUB  = 12'h002;
    localparam logic [PKG_OPCODE_W-1:0] OP_AND  = 12'h003;
    localparam logic [PKG_OPCODE_W-1:0] OP_OR   = 12'h004;
    localparam logic [PKG_OPCODE_W-1:0] OP_XOR  = 12'h005;
    localparam logic [PKG_OPCODE_W-1:0] OP_NOR  = 12'h006;
    localparam logic [PKG_OPCODE_W-1:0] OP_SLT  = 12'h007;
    // Immediate-operand ops
    localparam logic [PKG_OPCODE_W-1:0] OP_ADDI = 12'h008;
    localparam logic [PKG_OPCODE_W-1:0] OP_ANDI = 12'h009;
    localparam logic [PKG_OPCODE_W-1:0] OP_ORI  = 12'h00A;
    localparam logic [PKG_OPCODE_W-1:0] OP_XORI = 12'h00B;
    localparam logic [PKG_OPCODE_W-1:0] OP_SLL  = 12'h00C;
    localparam logic [PKG_OPCODE_W-1:0] OP_SRL  = 12'h00D;
    localparam logic [PKG_OPCODE_W-1:0] OP_SLTI = 12'h00E;
    // Memory
    localparam logic [PKG_OPCODE_W-1:0] OP_LW   = 12'h00F;
    localparam logic [PKG_OPCODE_W-1:0] OP_SW   = 12'h010;
    // Control flow
    localparam logic [PKG_OPCODE_W-1:0] OP_BEQ  = 12'h011;
    localparam logic [PKG_OPCODE_W-1:0] OP_BNE  = 12'h012;
    localparam logic [PKG_OPCODE_W-1:0] OP_JR   = 12'h013;
    localparam logic [PKG_OPCODE_W-1:0] OP_JAL  = 12'h014;
    localparam logic [PKG_OPCODE_W-1:0] OP_J    = 12'h015;
    // Multi-cycle R-type ops
    localparam logic [PKG_OPCODE_W-1:0] OP_MUL  = 12'h016;
    localparam logic [PKG_OPCODE_W-1:0] OP_DIV  = 12'h017;

    // Control bundle, MSB first in this order.
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic oper2_immed;
        logic is_beq;
        logic is_bne;
        logic is_jr;
        logic is_jal;
        logic is_j;
        logic is_muldiv;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } muldiv_state_t;

endpackage

// File: rtl/decode_ctrl_stage_ctrl_decode.sv
// Combinational opcode decoder: opcode + valid -> control bundle and a flag
// saying whether the instruction consumes rs2 (used by hazard detection).
module ctrl_decode
    import decode_ctrl_stage_pkg::*;
#(
    parameter int OPCODE_W = 12
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                valid_i,
    output ctrl_bundle_t        bundle_o,
    output logic                reads_rs2_o
);

    // Decode the opcode; an invalid slot yields an all-zero bundle.
    always_comb begin
        bundle_o    = CTRL_BUBBLE;
        reads_rs2_o = 1'b0;
        if (valid_i) begin
            case (opcode_i)
                OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_AND),
                OPCODE_W'(OP_OR),  OPCODE_W'(OP_XOR), OPCODE_W'(OP_NOR),
                OPCODE_W'(OP_SLT): begin
                    bundle_o.regwrite = 1'b1;
                    reads_rs2_o       = 1'b1;
                end
                OPCODE_W'(OP_MUL), OPCODE_W'(OP_DIV): begin
                    bundle_o.regwrite  = 1'b1;
                    bundle_o.is_muldiv = 1'b1;
                    reads_rs2_o        = 1'b1;
                end
                OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ANDI), OPCODE_W'(OP_ORI),
                OPCODE_W'(OP_XORI), OPCODE_W'(OP_SLL),  OPCODE_W'(OP_SRL),
                OPCODE_W'(OP_SLTI): begin
                    bundle_o.regwrite    = 1'b1;
                    bundle_o.oper2_immed = 1'b1;
                end
                OPCODE_W'(OP_LW): begin
                    bundle_o.regwrite    = 1'b1;
                    bundle_o.memread     = 1'b1;
                    bundle_o.oper2_immed = 1'b1;
                end
                OPCODE_W'(OP_SW): begin
                    bundle_o.memwrite    = 1'b1;
                    bundle_o.oper2_immed = 1'b1;
                    reads_rs2_o          = 1'b1;
                end
                OPCODE_W'(OP_BEQ): begin
                    bundle_o.is_beq = 1'b1;
                    reads_rs2_o     = 1'b1;
                end
                OPCODE_W'(OP_BNE): begin
                    bundle_o.is_bne = 1'b1;
                    reads_rs2_o     = 1'b1;
                end
                OPCODE_W'(OP_JR): begin
                    bundle_o.is_jr = 1'b1;
                end
                OPCODE_W'(OP_JAL): begin
                    bundle_o.regwrite = 1'b1;
                    bundle_o.is_jal   = 1'b1;
                end
                OPCODE_W'(OP_J): begin
                    bundle_o.is_j = 1'b1;
                end
                // Unknown opcodes are treated as a plain register-writing op.
                default: begin
                    bundle_o.regwrite = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// ID/EX control register with load-use bubble insertion, branch/jump flush
// and a busy FSM that holds EX for the full latency of mul/div.
module decode_ctrl_stage
    import decode_ctrl_stage_pkg::*;
#(
    parameter int OPCODE_W   = 12,
    parameter int REG_W      = 5,
    parameter int MULDIV_LAT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] ID_opcode,
    input  logic                ID_valid,
    input  logic [REG_W-1:0]    ID_rs1,
    input  logic [REG_W-1:0]    ID_rs2,
    input  logic [REG_W-1:0]    ID_rd,
    input  logic                EX_flush,
    output logic                EX_regwrite,
    output logic                EX_memread,
    output logic                EX_memwrite,
    output logic                EX_is_oper2_immed,
    output logic                EX_is_beq,
    output logic                EX_is_bne,
    output logic                EX_is_jr,
    output logic                EX_is_jal,
    output logic                EX_is_j,
    output logic                EX_is_muldiv,
    output logic [REG_W-1:0]    EX_rd,
    output logic                stall,
    output logic                muldiv_busy
);

    localparam int CNT_W = $clog2(MULDIV_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 2);

    ctrl_bundle_t     ex_d;
    logic             reads_rs2;
    logic [REG_W-1:0] ex_rd_d;

    ctrl_bundle_t     ex_q;
    logic [REG_W-1:0] ex_rd_q;
    muldiv_state_t    state_q;
    logic [CNT_W-1:0] cnt_q;

    logic             busy;
    logic             load_use;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_ctrl_decode (
        .opcode_i    (ID_opcode),
        .valid_i     (ID_valid),
        .bundle_o    (ex_d),
        .reads_rs2_o (reads_rs2)
    );

    assign ex_rd_d = ID_valid ? ID_rd : '0;
    assign busy    = (state_q == ST_BUSY);

    // Load-use: a load in EX whose (non-zero) destination feeds the ID op.
    always_comb begin
        load_use = 1'b0;
        if (ex_q.memread && (ex_rd_q != '0) && ID_valid) begin
            load_use = (ex_rd_q == ID_rs1) || ((ex_rd_q == ID_rs2) && reads_rs2);
        end
    end

    // Stall while mul/div is busy or on a load-use hit; flush and reset win.
    assign stall = !rst && !EX_flush && (busy || load_use);

    // ID/EX control register and mul/div FSM, priority: rst, flush, busy, load-use, normal.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= CTRL_BUBBLE;
            ex_rd_q <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (EX_flush) begin
            ex_q    <= CTRL_BUBBLE;
            ex_rd_q <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (busy) begin
            // EX holds the mul/div until the counter expires.
            if (cnt_q == '0) begin
                state_q <= ST_IDLE;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end else if (load_use) begin
            ex_q    <= CTRL_BUBBLE;
            ex_rd_q <= '0;
        end else begin
            ex_q    <= ex_d;
            ex_rd_q <= ex_rd_d;
            if (ex_d.is_muldiv) begin
                state_q <= ST_BUSY;
                cnt_q   <= CNT_LOAD;
            end
        end
    end

    assign EX_regwrite       = ex_q.regwrite;
    assign EX_memread        = ex_q.memread;
    assign EX_memwrite       = ex_q.memwrite;
    assign EX_is_oper2_immed = ex_q.oper2_immed;
    assign EX_is_beq         = ex_q.is_beq;
    assign EX_is_bne         = ex_q.is_bne;
    assign EX_is_jr          = ex_q.is_jr;
    assign EX_is_jal         = ex_q.is_jal;
    assign EX_is_j           = ex_q.is_j;
    assign EX_is_muldiv      = ex_q.is_muldiv;
    assign EX_rd             = ex_rd_q;
    assign muldiv_busy       = busy;

endmodule
